// File: rtl/rand_arbiter.sv
// Round-robin arbiter sharing one random-number generator between several requesters.
// Each grant pulses gen_start once, captures the burst and hands it over with valid/ack.
module rand_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int NUMLEN      = 4,
    parameter int RCOUNT      = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         rvalid,
    output logic [NUMLEN*RCOUNT-1:0]   rdata,
    output logic                       gen_start,
    input  logic [NUMLEN*RCOUNT-1:0]   gen_randoms,
    output logic                       busy,
    output logic                       drop
);
    localparam int DW = NUMLEN * RCOUNT;
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DELIVER} state_t;

    state_t            state, state_d;
    logic [NUM_REQ-1:0] gnt_d, rvalid_d;
    logic [DW-1:0]     rdata_d;
    logic [PW-1:0]     ptr, ptr_d, g, g_d, sel;
    logic [TW-1:0]     tcnt, tcnt_d;
    logic              drop_d, found, timeout, done;

    // First requester at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[(int'(ptr) + i) % NUM_REQ]) begin
                found = 1'b1;
                sel   = PW'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

    assign timeout = (ACK_TIMEOUT != 0) && (tcnt == TW'(ACK_TIMEOUT - 1));
    assign done    = ack[g] || timeout;

    always_comb begin
        state_d  = state;
        gnt_d    = gnt;
        rvalid_d = rvalid;
        rdata_d  = rdata;
        ptr_d    = ptr;
        g_d      = g;
        tcnt_d   = tcnt;
        drop_d   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    g_d = sel;
                    for (int i = 0; i < NUM_REQ; i++) gnt_d[i] = (sel == PW'(i));
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                rdata_d  = gen_randoms;
                rvalid_d = gnt;
                tcnt_d   = '0;
                state_d  = DELIVER;
            end
            DELIVER: begin
                if (done) begin
                    gnt_d    = '0;
                    rvalid_d = '0;
                    ptr_d    = (g == PW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
                    // Ack on the last allowed cycle still counts as a normal completion.
                    drop_d   = !ack[g];
                    state_d  = IDLE;
                end else begin
                    tcnt_d = tcnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            gnt    <= '0;
            rvalid <= '0;
            rdata  <= '0;
            ptr    <= '0;
            g      <= '0;
            tcnt   <= '0;
            drop   <= 1'b0;
        end else begin
            state  <= state_d;
            gnt    <= gnt_d;
            rvalid <= rvalid_d;
            rdata  <= rdata_d;
            ptr    <= ptr_d;
            g      <= g_d;
            tcnt   <= tcnt_d;
            drop   <= drop_d;
        end
    end

    assign gen_start = (state == ISSUE);
    assign busy      = (state != IDLE);

endmodule

// File: doc/rand_arbiter.md
Name: rand_arbiter

Overview:
- Shares the single random-number generator between several game-logic requesters (obstacle spawner, cloud spawner, score-effects).
- Arbitrates requests round-robin and drives the generator's start strobe for exactly one cycle per grant.
- Captures the generator's packed random word and delivers it to the granted requester with a valid/ack handshake.
- An acknowledge timeout prevents a stalled requester from locking out the others.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- NUMLEN, 4, bits per random number (matches generator NUM length).
- RCOUNT, 4, numbers per generator burst; data width = NUMLEN*RCOUNT.
- ACK_TIMEOUT, 15, DELIVER cycles allowed before the transaction is dropped; 0 disables the timeout.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req  in  NUM_REQ  per-requester request level.
- ack  in  NUM_REQ  per-requester acknowledge; only the granted bit is honoured.
- gnt  out  NUM_REQ  one-hot grant, registered.
- rvalid  out  NUM_REQ  one-hot data valid, registered.
- rdata  out  NUMLEN*RCOUNT  captured random word, shared bus.
- gen_start  out  1  start strobe to the generator.
- gen_randoms  in  NUMLEN*RCOUNT  generator output; updated at the edge that samples gen_start.
- busy  out  1  high whenever the state is not IDLE.
- drop  out  1  one-cycle pulse when a transaction times out.

Behaviour:
- Reset (async, any state): state=IDLE, gnt=0, rvalid=0, rdata=0, gen_start=0, busy=0, drop=0, ptr=0, tcnt=0.
- FSM states: IDLE, ISSUE, CAPTURE, DELIVER. All outputs decode from registered state/regs; no combinational input-to-output paths.
- IDLE:
  - If any req bit is set, select the first set index g scanning ptr, ptr+1, ... with wrap mod NUM_REQ.
  - Latch g, set gnt=onehot(g), go to ISSUE.
  - If no req is set, stay in IDLE.
- ISSUE: gen_start=1 for this single cycle. Next state CAPTURE.
- CAPTURE: gen_start=0; gen_randoms is new this cycle. At the next edge: rdata<=gen_randoms, rvalid<=onehot(g), tcnt<=0, go to DELIVER.
- DELIVER: rvalid and gnt held. Each edge:
  - ack[g]=1: rvalid=0, gnt=0, ptr=(g+1) mod NUM_REQ, go to IDLE.
  - Otherwise, if ACK_TIMEOUT!=0 and tcnt==ACK_TIMEOUT-1: same exit as ack, plus drop=1 for one cycle.
  - Otherwise tcnt++.
- tcnt width is clog2(ACK_TIMEOUT+1). An ack that coincides with the timeout wins; drop stays 0.
- Latency: req first sampled at edge E0 → gen_start high E0..E1 → rvalid rises at E2. Minimum request-to-request period is 4 cycles (IDLE, ISSUE, CAPTURE, DELIVER with ack in the first DELIVER cycle).
- Ignored inputs:
  - ack bits other than g are ignored.
  - ack while not in DELIVER is ignored.
  - req changes after the grant are ignored; a withdrawn req does not abort. The transaction completes normally or via timeout.
- rdata holds its last captured value after delivery; it only changes in CAPTURE→DELIVER.
- gen_start is never high in two consecutive cycles, and never high outside ISSUE.
- Reset asserted mid-ISSUE/CAPTURE/DELIVER: immediate return to the reset values above; no pending delivery survives. After reset release the first grant goes to the lowest requesting index (ptr=0).
- NUM_REQ=1: ptr stays 0; behaviour is otherwise identical.

Test Plan:
- Single request: req=3'b001 at E0; generator model returns 16'hA5C3 → gen_start high exactly one cycle (E0..E1); rvalid=3'b001 and rdata=16'hA5C3 from E2; ack[0] at E2 → IDLE at E3; busy low at E3.
- Round-robin: req=3'b111 held, immediate acks → grant order 0,1,2,0, each transaction spaced 4 cycles, one gen_start per grant.
- Timeout: req=3'b010, never ack → rvalid[1] held 15 cycles, then drop pulses once; next grant with req=3'b111 goes to index 2 (ptr wrapped past 1).
- Ack filtering: during DELIVER for g=0, ack=3'b110 for 3 cycles → no state change; then ack=3'b001 → exit. Ack coinciding with the final timeout cycle → drop stays 0.
- Reset mid-DELIVER: assert reset while rvalid=3'b100 → rvalid, gnt, rdata, busy go to 0 asynchronously; after release with req=3'b101, first grant is index 0.
- Withdrawn request: req[2] drops during CAPTURE → rvalid[2] still asserts with the captured word, and completes on ack[2].
